main_ram_arbiter: RTL and testbench

- Shares the single-port main_ram bus (15-bit word address, 32-bit data, 4 byte-enables, 1-cycle read latency) between NUM_REQ requesters.
- Port 0 is the host/CPU bus interface and gets fixed priority, bounded by a starvation limit.
- Ports 1..NUM_REQ-1 (layer renderers, sprite fetch, etc.) are served round-robin.
- One RAM access is granted per clock. The block sits directly in front of main_ram.

---
 rtl/main_ram_arbiter_pkg.sv | 24 ++
 rtl/main_ram_arbiter_if.sv | 30 +++
 rtl/main_ram_arbiter_rr_arbiter.sv | 41 ++++
 rtl/main_ram_arbiter.sv | 118 +++++++++++
 tb/tb_main_ram_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/main_ram_arbiter_pkg.sv
// Shared definitions for the main_ram arbiter: RAM bus geometry, the
// granted-request payload and a small index-width helper.
package main_ram_arbiter_pkg;

  localparam int unsigned RAM_ADDR_W     = 15;
  localparam int unsigned RAM_DATA_W     = 32;
  localparam int unsigned RAM_BE_W       = 4;
  localparam int unsigned RAM_RD_LATENCY = 1;
  localparam int unsigned STARVE_W       = 8;

  // Fields of the request currently driven onto the RAM bus.
  typedef struct packed {
    logic                  write;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wrdata;
    logic [RAM_BE_W-1:0]   bytesel;
  } ram_req_t;

  // Index width for an n-entry vector, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/main_ram_arbiter_if.sv
// Requester-side bus of the main_ram arbiter.
//   master : requesters drive req_*, receive req_ack / rd_valid / rd_data
//   slave  : the arbiter
// Flattened fields: port i occupies [i*W +: W].
interface main_ram_arbiter_if
  import main_ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*RAM_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*RAM_DATA_W-1:0] req_wrdata;
  logic [NUM_REQ*RAM_BE_W-1:0]   req_wrbytesel;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [RAM_DATA_W-1:0]         rd_data;

  modport master (
    output req_valid, req_write, req_addr, req_wrdata, req_wrbytesel,
    input  req_ack, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wrdata, req_wrbytesel,
    output req_ack, rd_valid, rd_data
  );

endinterface

// File: rtl/main_ram_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first set request scanning from ptr_i
// upward with wrap-around.
//   req_i   : request vector
//   ptr_i   : index to start the scan at
//   gnt_o   : one-hot grant
//   idx_o   : encoded grant index
//   valid_o : any grant
module rr_arbiter
  import main_ram_arbiter_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan N candidates starting at ptr_i; the first hit wins.
  always_comb begin
    int unsigned     cand;
    logic [IDX_W-1:0] c;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    c       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      c    = IDX_W'(cand);
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/main_ram_arbiter.sv
// Arbiter in front of the single-port main_ram. Port 0 (host) has fixed
// priority, capped at STARVE_LIMIT consecutive grants while others wait;
// ports 1..NUM_REQ-1 share the rest round-robin. One access per clock,
// grant and RAM fields combinational, read data returned one cycle later.
//   clk, rst_n     : clock, async active-low reset
//   bus            : requester interface (slave side)
//   ram_addr/ram_wrdata/ram_wrbytesel/ram_write : to main_ram
//   ram_rddata     : from main_ram, passed through to bus.rd_data
module main_ram_arbiter
  import main_ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  main_ram_arbiter_if.slave     bus,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [RAM_DATA_W-1:0] ram_wrdata,
  output logic [RAM_BE_W-1:0]   ram_wrbytesel,
  output logic                  ram_write,
  input  logic [RAM_DATA_W-1:0] ram_rddata
);

  localparam int unsigned RR_N     = NUM_REQ - 1;
  localparam int unsigned RR_IDX_W = idx_width(RR_N);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [RR_IDX_W-1:0]  RR_LAST    = RR_IDX_W'(RR_N - 1);

  // rr_ptr_q holds (port - 1), so reset value 0 points at port 1.
  logic [RR_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;

  logic                other_pending_c;
  logic                grant0_c;
  logic [RR_N-1:0]     rr_req_c;
  logic [RR_N-1:0]     rr_gnt_c;
  logic [RR_IDX_W-1:0] rr_idx_c;
  logic                rr_valid_c;
  logic [NUM_REQ-1:0]  ack_c;
  ram_req_t            sel_c;

  rr_arbiter #(
    .N (RR_N)
  ) u_rr (
    .req_i   (rr_req_c),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt_c),
    .idx_o   (rr_idx_c),
    .valid_o (rr_valid_c)
  );

  // Grant decision; rst_n gates all grants so nothing is acked in reset.
  always_comb begin
    other_pending_c = |bus.req_valid[NUM_REQ-1:1];
    grant0_c = rst_n & bus.req_valid[0] &
               ((starve_cnt_q < STARVE_MAX) | ~other_pending_c);
    rr_req_c = rst_n ? bus.req_valid[NUM_REQ-1:1] : '0;
    ack_c    = '0;
    if (grant0_c) begin
      ack_c[0] = 1'b1;
    end else if (rr_valid_c) begin
      ack_c = {rr_gnt_c, 1'b0};
    end
  end

  // One-hot AND-OR mux of the granted port's fields; zero when idle.
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_c[i]) begin
        sel_c.write   = bus.req_write[i];
        sel_c.addr    = bus.req_addr[i*RAM_ADDR_W +: RAM_ADDR_W];
        sel_c.wrdata  = bus.req_wrdata[i*RAM_DATA_W +: RAM_DATA_W];
        sel_c.bytesel = bus.req_wrbytesel[i*RAM_BE_W +: RAM_BE_W];
      end
    end
  end

  // Next state for priority counter, round-robin pointer and read return.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    rd_valid_d   = ack_c & ~bus.req_write;
    if (grant0_c) begin
      if (!other_pending_c) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q < STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end else if (rr_valid_c) begin
      starve_cnt_d = '0;
      rr_ptr_d     = (rr_idx_c == RR_LAST) ? '0 : rr_idx_c + RR_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      rd_valid_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign bus.req_ack    = ack_c;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = ram_rddata;
  assign ram_addr       = sel_c.addr;
  assign ram_wrdata     = sel_c.wrdata;
  assign ram_wrbytesel  = sel_c.bytesel;
  assign ram_write      = sel_c.write;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Bench for main_ram_arbiter: a byte-enable RAM model with one-cycle read
// latency, a table of single-cycle vectors, then directed sequences for
// round-robin, starvation, idle hold and asynchronous reset.
module tb_main_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;

  int total;
  int bad;

  main_ram_arbiter_if #(.NUM_REQ(4)) bus ();

  main_ram_arbiter #(
    .NUM_REQ      (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .ram_addr      (ram_addr),
    .ram_wrdata    (ram_wrdata),
    .ram_wrbytesel (ram_wrbytesel),
    .ram_write     (ram_write),
    .ram_rddata    (ram_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: unwritten words read as their own address, except 0x1000.
  logic [31:0] mem     [0:32767];
  bit          written [0:32767];

  function automatic logic [31:0] mem_rd(input logic [14:0] a);
    if (written[a]) return mem[a];
    if (a == 15'h1000) return 32'h12345678;
    return {17'd0, a};
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    ram_rddata <= mem_rd(ram_addr);
    if (ram_write) begin
      w = mem_rd(ram_addr);
      for (int b = 0; b < 4; b++)
        if (ram_wrbytesel[b]) w[b*8 +: 8] = ram_wrdata[b*8 +: 8];
      mem[ram_addr]     = w;
      written[ram_addr] = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w);
    bus.req_valid = v;
    bus.req_write = w;
  endtask

  // One cycle: drive at negedge, check ack (and idle bus), then rd_valid.
  task automatic cyc_ack(input string nm, input logic [3:0] v, input logic [3:0] w,
                         input logic [3:0] exp_ack);
    @(negedge clk);
    drive(v, w);
    #1;
    chk({nm, "_ack"}, 64'(bus.req_ack), 64'(exp_ack));
    chk({nm, "_ack_onehot"}, 64'($onehot0(bus.req_ack)), 64'd1);
    if (exp_ack == 4'b0000) begin
      chk({nm, "_idle_addr"}, 64'(ram_addr), 64'd0);
      chk({nm, "_idle_write"}, 64'(ram_write), 64'd0);
    end
    @(posedge clk);
    #1;
    chk({nm, "_rdv_onehot"}, 64'($onehot0(bus.rd_valid)), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [3:0]  ack;
    logic [14:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  rdv;
    logic [31:0] rdd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_seq [6];
    total = 0;
    bad   = 0;

    // Fixed per-port fields: port 3..0.
    bus.req_addr      = {15'h7FFF, 15'h1000, 15'h4005, 15'h0010};
    bus.req_wrdata    = {32'h44444444, 32'h33333333, 32'hAABBCCDD, 32'h11111111};
    bus.req_wrbytesel = {4'hF, 4'hF, 4'b0101, 4'hF};

    //           valid    write    ack      addr     wr    wdata          be    rdv      rdd
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 15'h0000, 1'b0, 32'h00000000, 4'h0, 4'b0000, 32'h0};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 15'h1000, 1'b0, 32'h33333333, 4'hF, 4'b0100, 32'h12345678};
    tbl[2]  = '{4'b0010, 4'b0010, 4'b0010, 15'h4005, 1'b1, 32'hAABBCCDD, 4'h5, 4'b0000, 32'h0};
    tbl[3]  = '{4'b0010, 4'b0000, 4'b0010, 15'h4005, 1'b0, 32'hAABBCCDD, 4'h5, 4'b0010, 32'h00BB40DD};
    tbl[4]  = '{4'b1110, 4'b0000, 4'b0100, 15'h1000, 1'b0, 32'h33333333, 4'hF, 4'b0100, 32'h12345678};
    tbl[5]  = '{4'b1110, 4'b0000, 4'b1000, 15'h7FFF, 1'b0, 32'h44444444, 4'hF, 4'b1000, 32'h00007FFF};
    tbl[6]  = '{4'b1110, 4'b0000, 4'b0010, 15'h4005, 1'b0, 32'hAABBCCDD, 4'h5, 4'b0010, 32'h00BB40DD};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0001, 15'h0010, 1'b0, 32'h11111111, 4'hF, 4'b0001, 32'h00000010};
    tbl[8]  = '{4'b0001, 4'b0001, 4'b0001, 15'h0010, 1'b1, 32'h11111111, 4'hF, 4'b0000, 32'h0};
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0001, 15'h0010, 1'b0, 32'h11111111, 4'hF, 4'b0001, 32'h11111111};
    tbl[10] = '{4'b1000, 4'b1000, 4'b1000, 15'h7FFF, 1'b1, 32'h44444444, 4'hF, 4'b0000, 32'h0};
    tbl[11] = '{4'b1100, 4'b0000, 4'b0100, 15'h1000, 1'b0, 32'h33333333, 4'hF, 4'b0100, 32'h12345678};
    tbl[12] = '{4'b1000, 4'b0000, 4'b1000, 15'h7FFF, 1'b0, 32'h44444444, 4'hF, 4'b1000, 32'h44444444};

    // Reset state: nothing acked or written even with every port requesting.
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111);
    #3;
    chk("rst_ack", 64'(bus.req_ack), 64'd0);
    chk("rst_ram_write", 64'(ram_write), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    @(negedge clk);
    drive(4'b0000, 4'b0000);
    rst_n = 1'b1;

    for (int r = 0; r < 13; r++) begin
      string nm;
      nm = $sformatf("vec%0d", r);
      @(negedge clk);
      drive(tbl[r].valid, tbl[r].write);
      #1;
      chk({nm, "_ack"}, 64'(bus.req_ack), 64'(tbl[r].ack));
      chk({nm, "_addr"}, 64'(ram_addr), 64'(tbl[r].addr));
      chk({nm, "_write"}, 64'(ram_write), 64'(tbl[r].wr));
      chk({nm, "_wrdata"}, 64'(ram_wrdata), 64'(tbl[r].wdata));
      chk({nm, "_be"}, 64'(ram_wrbytesel), 64'(tbl[r].be));
      @(posedge clk);
      #1;
      chk({nm, "_rd_valid"}, 64'(bus.rd_valid), 64'(tbl[r].rdv));
      if (tbl[r].rdv != 4'b0000)
        chk({nm, "_rd_data"}, 64'(bus.rd_data), 64'(tbl[r].rdd));
    end

    // Round-robin over ports 1..3 with port 0 idle.
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 6; i++)
      cyc_ack($sformatf("rr%0d", i), 4'b1110, 4'b0000, exp_seq[i]);

    // Starvation: eight host grants then one port-3 grant, twice.
    for (int i = 0; i < 18; i++)
      cyc_ack($sformatf("starve%0d", i), 4'b1001, 4'b0000,
              ((i % 9) == 8) ? 4'b1000 : 4'b0001);

    // Idle bus holds state: counter at 3 survives 16 idle cycles.
    cyc_ack("pre_idle_p2", 4'b0100, 4'b0000, 4'b0100);
    for (int i = 0; i < 3; i++)
      cyc_ack($sformatf("pre_idle_h%0d", i), 4'b1001, 4'b0000, 4'b0001);
    for (int i = 0; i < 16; i++)
      cyc_ack($sformatf("idle%0d", i), 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++)
      cyc_ack($sformatf("post_idle%0d", i), 4'b1001, 4'b0000,
              (i == 5) ? 4'b1000 : 4'b0001);
    for (int i = 0; i < 2; i++)
      cyc_ack($sformatf("idle_b%0d", i), 4'b0000, 4'b0000, 4'b0000);
    cyc_ack("post_idle_rr", 4'b1110, 4'b0000, 4'b0010);

    // Async reset right after an accepted read from port 2.
    @(negedge clk);
    drive(4'b0100, 4'b0000);
    #1;
    chk("prerst_ack", 64'(bus.req_ack), 64'b0100);
    @(posedge clk);
    #1;
    chk("prerst_rd_valid", 64'(bus.rd_valid), 64'b0100);
    #1;
    drive(4'b1111, 4'b1111);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("arst_ack", 64'(bus.req_ack), 64'd0);
    chk("arst_ram_write", 64'(ram_write), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_rd_valid", 64'(bus.rd_valid), 64'd0);
    @(negedge clk);
    drive(4'b1111, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk("rel_ack_p0", 64'(bus.req_ack), 64'b0001);
    @(posedge clk);
    #1;
    chk("rel_rd_valid", 64'(bus.rd_valid), 64'b0001);
    cyc_ack("rel_rr_p1", 4'b1110, 4'b0000, 4'b0010);
    cyc_ack("rel_end", 4'b0000, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
